step_ramp_generator: RTL and testbench

Trapezoidal-profile step/direction generator placed directly upstream of the stepper driver. It accepts an absolute target position over a valid/ready command interface and emits `step_out` and `dir_out` to drive the driver's step and direction inputs. It accelerates from a start period to a minimum period, cruises, and decelerates symmetrically. It tracks the commanded position, which mirrors the driver's internal step count.

---
 rtl/step_ramp_generator.sv | 214 +++++++++++++++++++++
 tb/tb_step_ramp_generator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/step_ramp_generator.sv
// step_ramp_generator
//
// Trapezoidal-profile step/direction generator for a stepper driver. It takes
// an absolute target position over a valid/ready interface and emits
// step_out/dir_out. It accelerates from cfg_start_period toward
// cfg_min_period, cruises, then decelerates symmetrically. position mirrors
// the driver's internal step count.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cmd_valid         command offered
//   cmd_ready         high only in IDLE
//   cmd_target        signed absolute target position
//   cfg_start_period  slowest step period (cycles), latched at accept
//   cfg_min_period    fastest step period (cycles), latched at accept
//   cfg_accel         period change per step, latched at accept
//   abort             level; requests a controlled stop while busy
//   step_out          registered step pulse, PULSE_W cycles high
//   dir_out           registered direction, 1 = increasing, held between moves
//   position          current commanded position
//   busy              high when not in IDLE
//   done              one-cycle pulse at the end of each accepted command
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a command; cmd_ready high
// ACCEL  | period shrinking by cfg_accel on each step toward min period
// CRUISE | stepping at min period until remaining <= ramp_count
// DECEL  | period growing by cfg_accel on each step back to start period

module step_ramp_generator #(
    parameter int POS_W   = 32,
    parameter int PER_W   = 24,
    parameter int PULSE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [POS_W-1:0] cmd_target,
    input  logic [PER_W-1:0] cfg_start_period,
    input  logic [PER_W-1:0] cfg_min_period,
    input  logic [PER_W-1:0] cfg_accel,
    input  logic             abort,
    output logic             step_out,
    output logic             dir_out,
    output logic [POS_W-1:0] position,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEL  = 2'd1,
        CRUISE = 2'd2,
        DECEL  = 2'd3
    } state_t;

    localparam int PC_W = $clog2(PULSE_W + 1);
    // The step period may never be shorter than the pulse plus an equal low time.
    localparam logic [PER_W-1:0] MIN_EFF   = PER_W'(2 * PULSE_W);
    localparam logic [PC_W-1:0]  PULSE_LEN = PC_W'(PULSE_W);

    state_t           state_q, state_d;
    state_t           cur_state;
    logic [PER_W-1:0] period_q, period_d;
    logic [PER_W-1:0] start_q, min_q, accel_q;
    logic [PER_W-1:0] eff_period;
    logic [PER_W-1:0] timer_q, timer_d;
    logic [POS_W-1:0] ramp_q, ramp_d;
    logic [POS_W-1:0] rem_q, rem_d, rem_n;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic             accept, emit;
    logic [POS_W:0]   delta, delta_abs;
    logic [PC_W-1:0]  pulse_cnt_q;
    logic             step_q;

    assign accept     = (state_q == IDLE) && cmd_valid;
    assign delta      = {cmd_target[POS_W-1], cmd_target} - {pos_q[POS_W-1], pos_q};
    assign delta_abs  = delta[POS_W] ? (~delta + 1'b1) : delta;
    assign eff_period = (period_q < MIN_EFF) ? MIN_EFF : period_q;
    assign emit       = (state_q != IDLE) && (timer_q == eff_period - PER_W'(1));

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign step_out  = step_q;
    assign dir_out   = dir_q;
    assign position  = pos_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            period_q <= '0;
            timer_q  <= '0;
            ramp_q   <= '0;
            rem_q    <= '0;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            timer_q  <= timer_d;
            ramp_q   <= ramp_d;
            rem_q    <= rem_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
        end
    end

    // Move configuration is frozen for the duration of a move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
            min_q   <= '0;
            accel_q <= '0;
        end else if (accept) begin
            start_q <= cfg_start_period;
            min_q   <= (cfg_min_period > cfg_start_period) ? cfg_start_period : cfg_min_period;
            accel_q <= cfg_accel;
        end
    end

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        timer_d   = timer_q;
        ramp_d    = ramp_q;
        rem_d     = rem_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        abort_d   = abort_q;
        rem_n     = rem_q;
        cur_state = state_q;

        if (state_q == IDLE) begin
            abort_d = 1'b0;
            if (cmd_valid) begin
                if (delta == '0) begin
                    done_d = 1'b1;
                end else begin
                    dir_d    = ~delta[POS_W];
                    rem_d    = delta_abs[POS_W-1:0];
                    period_d = cfg_start_period;
                    ramp_d   = '0;
                    timer_d  = '0;
                    state_d  = ACCEL;
                end
            end
        end else begin
            abort_d = abort_q | abort;
            if (!emit) begin
                timer_d = timer_q + PER_W'(1);
            end else begin
                timer_d = '0;
                pos_d   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                rem_n   = rem_q - POS_W'(1);
                // An abort shortens the move to exactly what is needed to ramp down.
                if (abort_d) begin
                    if (ramp_q < rem_n) rem_n = ramp_q;
                    cur_state = DECEL;
                end
                rem_d = rem_n;

                if (rem_n == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    abort_d = 1'b0;
                end else if (cur_state == ACCEL && rem_n > ramp_q) begin
                    ramp_d = ramp_q + POS_W'(1);
                    if (accel_q >= period_q - min_q) begin
                        period_d = min_q;
                        state_d  = CRUISE;
                    end else begin
                        period_d = period_q - accel_q;
                    end
                end else if (cur_state == CRUISE && rem_n > ramp_q) begin
                    state_d = CRUISE;
                end else begin
                    state_d = DECEL;
                    if (ramp_q != '0) begin
                        ramp_d   = ramp_q - POS_W'(1);
                        period_d = (accel_q >= start_q - period_q) ? start_q
                                                                   : period_q + accel_q;
                    end
                end
            end
        end
    end

    // Pulse stretcher runs independently of the FSM so a new move can be
    // accepted while the final pulse of the previous one is still high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q      <= 1'b0;
            pulse_cnt_q <= '0;
        end else if (emit) begin
            step_q      <= 1'b1;
            pulse_cnt_q <= PULSE_LEN;
        end else if (step_q) begin
            pulse_cnt_q <= pulse_cnt_q - PC_W'(1);
            if (pulse_cnt_q == PC_W'(1)) step_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_step_ramp_generator.sv
module tb_step_ramp_generator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_target = '0;
    logic [23:0] cfg_start_period = '0;
    logic [23:0] cfg_min_period = '0;
    logic [23:0] cfg_accel = '0;
    logic        abort = 1'b0;
    logic        step_out, dir_out, busy, done;
    logic [31:0] position;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int rises[0:127];
    int n_rise;
    int acc_cyc;
    int done_cyc;

    step_ramp_generator #(.POS_W(32), .PER_W(24), .PULSE_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cfg_start_period(cfg_start_period),
        .cfg_min_period(cfg_min_period), .cfg_accel(cfg_accel), .abort(abort),
        .step_out(step_out), .dir_out(dir_out), .position(position),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issue a command at a negedge and collect rise cycles until done.
    // abort_at: pulse abort right after that many rises (0 = never).
    // intrude: offer a bogus command for one cycle after the first rise.
    task automatic do_move(input logic [31:0] tgt, input int st, input int mn, input int ac,
                           input int abort_at, input bit intrude);
        logic prev;
        bit   ab_done;
        bit   got_done;
        ab_done  = 0;
        got_done = 0;
        n_rise   = 0;
        cmd_target       = tgt;
        cfg_start_period = 24'(st);
        cfg_min_period   = 24'(mn);
        cfg_accel        = 24'(ac);
        cmd_valid        = 1'b1;
        @(negedge clk);
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
        chk("ready_after_accept", {31'b0, cmd_ready}, 32'd0);
        prev = step_out;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (step_out && !prev) begin
                rises[n_rise] = cyc;
                n_rise++;
            end
            prev = step_out;
            if (intrude && n_rise == 1 && !ab_done) begin
                cmd_valid  = 1'b1;
                cmd_target = 32'd50;
                ab_done    = 1;
            end else begin
                cmd_valid  = 1'b0;
                cmd_target = tgt;
            end
            if (abort_at != 0 && n_rise == abort_at && !ab_done) begin
                abort   = 1'b1;
                ab_done = 1;
            end else begin
                abort = 1'b0;
            end
            if (done) begin
                done_cyc = cyc;
                got_done = 1;
                chk("busy_at_done", {31'b0, busy}, 32'd0);
                chk("ready_at_done", {31'b0, cmd_ready}, 32'd1);
                break;
            end
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
        chk("done_seen", {31'b0, got_done}, 32'd1);
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    task automatic chk_intervals(input string tag, input int exp_q[$], input int first);
        int prev_c;
        prev_c = (first == 0) ? acc_cyc : rises[first-1];
        for (int k = 0; k < exp_q.size(); k++) begin
            chk(tag, 32'(rises[first+k] - prev_c), 32'(exp_q[k]));
            prev_c = rises[first+k];
        end
    endtask

    initial begin
        int exp_trap[$];
        int exp_tri[$];
        int exp_ab[$];
        bit saw_step;

        exp_trap = '{20, 16, 12, 8, 8, 8, 8, 8, 12, 16, 20};
        exp_tri  = '{20, 16, 20};
        exp_ab   = '{8, 12, 16, 20};

        // reset state
        #12;
        chk("rst_step", {31'b0, step_out}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_pos", position, 32'd0);
        chk("rst_dir", {31'b0, dir_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, cmd_ready}, 32'd1);

        // constant speed: 0 -> 3, period 10
        do_move(32'd3, 10, 10, 0, 0, 0);
        chk("const_nsteps", 32'(n_rise), 32'd3);
        // first rise P0+1 = 11 cycles after accept (cycle 1 follows the accept edge)
        chk("const_first", 32'(rises[0] - acc_cyc + 1), 32'd11);
        chk("const_sp1", 32'(rises[1] - rises[0]), 32'd10);
        chk("const_sp2", 32'(rises[2] - rises[1]), 32'd10);
        chk("const_done_at_last", 32'(done_cyc), 32'(rises[2]));
        chk("const_dir", {31'b0, dir_out}, 32'd1);
        chk("const_pos", position, 32'd3);

        // trapezoid: 3 -> -8
        do_move(32'hFFFF_FFF8, 20, 8, 4, 0, 0);
        chk("trap_nsteps", 32'(n_rise), 32'd11);
        chk_intervals("trap_interval", exp_trap, 0);
        chk("trap_dir", {31'b0, dir_out}, 32'd0);
        chk("trap_pos", position, 32'hFFFF_FFF8);

        // triangle: 0 -> 3, with an ignored command during the move
        do_reset();
        do_move(32'd3, 20, 8, 4, 0, 1);
        chk("tri_nsteps", 32'(n_rise), 32'd3);
        chk_intervals("tri_interval", exp_tri, 0);
        chk("tri_pos", position, 32'd3);

        // abort after step 3 of a 100-step move
        do_reset();
        do_move(32'd100, 20, 8, 4, 3, 0);
        chk("abort_nsteps", 32'(n_rise), 32'd7);
        chk_intervals("abort_interval", exp_ab, 3);
        chk("abort_pos", position, 32'd7);

        // zero-distance command
        cmd_target = 32'd7;
        cmd_valid  = 1'b1;
        saw_step   = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("zero_done", {31'b0, done}, 32'd1);
        chk("zero_busy", {31'b0, busy}, 32'd0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (step_out) saw_step = 1;
            if (i == 0) chk("zero_done_clear", {31'b0, done}, 32'd0);
        end
        chk("zero_no_step", {31'b0, saw_step}, 32'd0);
        chk("zero_pos", position, 32'd7);

        // reset mid-move while step_out is high
        cmd_target       = 32'd200;
        cfg_start_period = 24'd20;
        cfg_min_period   = 24'd8;
        cfg_accel        = 24'd4;
        cmd_valid        = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        saw_step  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (step_out && position == 32'd9) begin
                saw_step = 1;
                break;
            end
        end
        chk("rstmid_reached", {31'b0, saw_step}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_step", {31'b0, step_out}, 32'd0);
        chk("rstmid_busy", {31'b0, busy}, 32'd0);
        chk("rstmid_done", {31'b0, done}, 32'd0);
        chk("rstmid_pos", position, 32'd0);
        chk("rstmid_dir", {31'b0, dir_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_ready", {31'b0, cmd_ready}, 32'd1);
        repeat (30) @(negedge clk);
        chk("rstmid_dropped", position, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
